pcie2_rsl: RTL



---
 rtl/pcie2_rsl_pkg.sv | 25 ++
 rtl/pcie2_rsl_refmon.sv | 65 ++++++
 rtl/pcie2_rsl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/pcie2_rsl_pkg.sv
// pcie2_rsl shared types: sequencer state encoding and default timing constants.
// Optional PLL-lock timeout is enabled with PCIE2_RSL_TIMEOUT_EN.
package pcie2_rsl_pkg;

  typedef enum logic [2:0] {
    REFWAIT = 3'd0,
    PLLRST  = 3'd1,
    PLLWAIT = 3'd2,
    TXUP    = 3'd3,
    RXWAIT  = 3'd4,
    RUN     = 3'd5
  } rsl_state_e;

  localparam int DEF_WINDOW      = 4096;
  localparam int DEF_HB_MIN      = 1536;
  localparam int DEF_HB_MAX      = 1740;
  localparam int DEF_PLL_RST_CYC = 64;
  localparam int DEF_LOCK_CYC    = 1024;
  localparam int DEF_TIMEOUT_CYC = 65536;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pcie2_rsl_refmon.sv
// Refclk presence monitor: counts heartbeat edges per window of clk cycles
// and qualifies refclk_ok with two-good-windows-to-set, one-bad-to-clear.
module pcie2_rsl_refmon
  import pcie2_rsl_pkg::*;
#(
  parameter int WINDOW = DEF_WINDOW,
  parameter int HB_MIN = DEF_HB_MIN,
  parameter int HB_MAX = DEF_HB_MAX
) (
  input  logic clk,
  input  logic rst,
  input  logic refclk_hb,
  output logic refclk_ok
);

  localparam int CW = $clog2(WINDOW + 1);
  localparam logic [CW-1:0] WIN_LAST = CW'(WINDOW - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] LO       = CW'(HB_MIN);
  localparam logic [CW-1:0] HI       = CW'(HB_MAX);

  logic [2:0]    hb_q, hb_d;
  logic [CW-1:0] win_q, win_d;
  logic [CW-1:0] edge_q, edge_d;
  logic [CW-1:0] tot;
  logic          good_q, good_d;
  logic          ok_q, ok_d;
  logic          hb_edge, wrap, in_rng;

  always_comb begin
    hb_d    = {hb_q[1:0], refclk_hb};
    hb_edge = hb_q[2] ^ hb_q[1];
    wrap    = (win_q == WIN_LAST);
    win_d   = wrap ? '0 : win_q + 1'b1;
    // The edge arriving on the wrap cycle still belongs to this window.
    tot     = (hb_edge && edge_q != CNT_MAX) ? edge_q + 1'b1 : edge_q;
    in_rng  = (tot >= LO) && (tot <= HI);
    edge_d  = wrap ? '0 : tot;
    good_d  = good_q;
    ok_d    = ok_q;
    if (wrap) begin
      good_d = in_rng;
      ok_d   = in_rng && good_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hb_q   <= '0;
      win_q  <= '0;
      edge_q <= '0;
      good_q <= 1'b0;
      ok_q   <= 1'b0;
    end else begin
      hb_q   <= hb_d;
      win_q  <= win_d;
      edge_q <= edge_d;
      good_q <= good_d;
      ok_q   <= ok_d;
    end
  end

  assign refclk_ok = ok_q;

endmodule

// File: rtl/pcie2_rsl.sv
// PCIe Gen2 SerDes reset sequencer: refclk check, TX PLL, RX CDR, PCS resets.
// Define PCIE2_RSL_TIMEOUT_EN to retry the PLL reset when lock never arrives.
module pcie2_rsl
  import pcie2_rsl_pkg::*;
#(
  parameter int WINDOW      = DEF_WINDOW,
  parameter int HB_MIN      = DEF_HB_MIN,
  parameter int HB_MAX      = DEF_HB_MAX,
  parameter int PLL_RST_CYC = DEF_PLL_RST_CYC,
  parameter int LOCK_CYC    = DEF_LOCK_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic refclk_hb,
  input  logic pll_lol,
  input  logic rx_cdr_lol,
  input  logic rx_los,
  output logic tx_serdes_rst,
  output logic tx_pcs_rst,
  output logic rx_serdes_rst,
  output logic rx_pcs_rst,
  output logic refclk_ok,
  output logic tx_ready,
  output logic rx_ready
);

  localparam int CMAX = max2(PLL_RST_CYC, LOCK_CYC);
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] RST_LAST  = CW'(PLL_RST_CYC - 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_CYC - 1);

  if (PLL_RST_CYC < 1 || LOCK_CYC < 1 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("pcie2_rsl: cycle counts must be at least 1");
  end

`ifdef PCIE2_RSL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] to_q, to_d;
`endif

  logic [1:0]    pll_q, pll_d;
  logic [1:0]    cdr_q, cdr_d;
  logic [1:0]    los_q, los_d;
  logic          pll_bad, rx_bad, ref_ok;
  rsl_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tx_serdes_rst_q, tx_serdes_rst_d;
  logic          tx_pcs_rst_q, tx_pcs_rst_d;
  logic          rx_serdes_rst_q, rx_serdes_rst_d;
  logic          rx_pcs_rst_q, rx_pcs_rst_d;
  logic          tx_ready_q, tx_ready_d;
  logic          rx_ready_q, rx_ready_d;
  logic          tx_up, rx_up;

  pcie2_rsl_refmon #(
    .WINDOW (WINDOW),
    .HB_MIN (HB_MIN),
    .HB_MAX (HB_MAX)
  ) u_refmon (
    .clk       (clk),
    .rst       (rst),
    .refclk_hb (refclk_hb),
    .refclk_ok (ref_ok)
  );

  always_comb begin
    pll_d   = {pll_q[0], pll_lol};
    cdr_d   = {cdr_q[0], rx_cdr_lol};
    los_d   = {los_q[0], rx_los};
    pll_bad = pll_q[1];
    rx_bad  = cdr_q[1] | los_q[1];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef PCIE2_RSL_TIMEOUT_EN
    to_d    = '0;
`endif
    unique case (state_q)
      REFWAIT: begin
        cnt_d = '0;
        if (ref_ok) state_d = PLLRST;
      end
      PLLRST: begin
        if (cnt_q == RST_LAST) begin
          state_d = PLLWAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PLLWAIT: begin
        if (pll_bad) begin
          cnt_d = '0;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = TXUP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`ifdef PCIE2_RSL_TIMEOUT_EN
        to_d = to_q + 1'b1;
        if (to_q == TO_LAST && state_d == PLLWAIT) begin
          state_d = PLLRST;
          cnt_d   = '0;
        end
`endif
      end
      TXUP: begin
        state_d = RXWAIT;
        cnt_d   = '0;
      end
      RXWAIT: begin
        if (rx_bad) begin
          cnt_d = '0;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (rx_bad) begin
          state_d = RXWAIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = REFWAIT;
        cnt_d   = '0;
      end
    endcase
    // Faults override whatever the per-state logic decided.
    if (state_q != REFWAIT) begin
      if (!ref_ok) begin
        state_d = REFWAIT;
        cnt_d   = '0;
      end else if (pll_bad && (state_q inside {TXUP, RXWAIT, RUN})) begin
        state_d = PLLRST;
        cnt_d   = '0;
      end
    end
  end

  always_comb begin
    tx_up           = state_q inside {TXUP, RXWAIT, RUN};
    rx_up           = state_q inside {RXWAIT, RUN};
    tx_serdes_rst_d = (state_q == REFWAIT) || (state_q == PLLRST);
    tx_pcs_rst_d    = !tx_up;
    tx_ready_d      = tx_up;
    rx_serdes_rst_d = !rx_up;
    rx_pcs_rst_d    = (state_q != RUN);
    rx_ready_d      = (state_q == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pll_q           <= '0;
      cdr_q           <= '0;
      los_q           <= '0;
      state_q         <= REFWAIT;
      cnt_q           <= '0;
      tx_serdes_rst_q <= 1'b1;
      tx_pcs_rst_q    <= 1'b1;
      rx_serdes_rst_q <= 1'b1;
      rx_pcs_rst_q    <= 1'b1;
      tx_ready_q      <= 1'b0;
      rx_ready_q      <= 1'b0;
    end else begin
      pll_q           <= pll_d;
      cdr_q           <= cdr_d;
      los_q           <= los_d;
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      tx_serdes_rst_q <= tx_serdes_rst_d;
      tx_pcs_rst_q    <= tx_pcs_rst_d;
      rx_serdes_rst_q <= rx_serdes_rst_d;
      rx_pcs_rst_q    <= rx_pcs_rst_d;
      tx_ready_q      <= tx_ready_d;
      rx_ready_q      <= rx_ready_d;
    end
  end

`ifdef PCIE2_RSL_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) to_q <= '0;
    else     to_q <= to_d;
  end
`endif

  assign tx_serdes_rst = tx_serdes_rst_q;
  assign tx_pcs_rst    = tx_pcs_rst_q;
  assign rx_serdes_rst = rx_serdes_rst_q;
  assign rx_pcs_rst    = rx_pcs_rst_q;
  assign refclk_ok     = ref_ok;
  assign tx_ready      = tx_ready_q;
  assign rx_ready      = rx_ready_q;

endmodule
